// File: rtl/dvi_video_pkg.sv
// Shared types for the DVI pixel fetch path: the 24-bit RGB pixel word
// and the fetch scheduler state encoding.
package dvi_video_pkg;

    typedef struct packed {
        logic [7:0] red;    // [23:16]
        logic [7:0] green;  // [15:8]
        logic [7:0] blue;   // [7:0]
    } pixel_t;

    localparam int PIXEL_W = $bits(pixel_t);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/dvi_pixel_fifo.sv
// Synchronous pixel FIFO with count/full/empty, same-cycle push+pop and a flush.
// Read data is the current head (zero latency); pushes when full and pops when empty are ignored.
module dvi_pixel_fifo
    import dvi_video_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = PIXEL_W
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/dvi_line_fetch_controller.sv
// Framebuffer read scheduler for the DVI pixel path: credit-limited burst requests into a pixel FIFO,
// one pixel popped per dataenable cycle and registered to R/G/B with de_out (1-cycle latency).
module dvi_line_fetch_controller
    import dvi_video_pkg::*;
#(
    parameter int                H_ACTIVE   = 640,
    parameter int                V_ACTIVE   = 480,
    parameter int                FIFO_DEPTH = 32,
    parameter int                BURST_LEN  = 8,
    parameter int                ADDR_W     = 24,
    parameter logic [ADDR_W-1:0] FB_BASE    = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_frame_start,
    input  logic              i_dataenable,
    output logic              o_rd_req,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_ack,
    input  logic              i_rd_valid,
    input  logic [23:0]       i_rd_data,
    output logic [7:0]        o_red,
    output logic [7:0]        o_green,
    output logic [7:0]        o_blue,
    output logic              o_de_out,
    output logic              o_underflow,
    output logic              o_overflow
);

    localparam int TOTAL_PIX = H_ACTIVE * V_ACTIVE;
    localparam int WR_W      = $clog2(TOTAL_PIX + 1);
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W     = CNT_W + 1;

    fetch_state_t      r_state;
    logic              r_rd_req;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [WR_W-1:0]   r_words_req;
    logic [OUT_W-1:0]  r_outstanding;
    logic [7:0]        r_red;
    logic [7:0]        r_green;
    logic [7:0]        r_blue;
    logic              r_de_out;
    logic              r_underflow;
    logic              r_overflow;

    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [PIXEL_W-1:0] w_fifo_rdata;
    pixel_t            w_head;
    logic              w_fetch;
    logic              w_push;
    logic              w_pop;
    logic              w_ack;
    logic              w_more;
    logic              w_credit_ok;
    logic [31:0]       w_credit_sum;
    logic [OUT_W-1:0]  w_out_next;

    assign w_fetch      = (r_state == ST_FETCH);
    assign w_ack        = r_rd_req && i_rd_ack;
    assign w_push       = w_fetch && i_rd_valid;
    assign w_pop        = i_dataenable && !w_fifo_empty;
    assign w_head       = pixel_t'(w_fifo_rdata);
    assign w_more       = (32'(r_words_req) < 32'(TOTAL_PIX));
    assign w_credit_sum = 32'(w_fifo_count) + 32'(r_outstanding) + 32'(BURST_LEN);
    assign w_credit_ok  = (w_credit_sum <= 32'(FIFO_DEPTH));
    // An accepted burst becomes outstanding in the same cycle any returning word retires one.
    assign w_out_next   = r_outstanding
                        + (w_ack ? OUT_W'(BURST_LEN) : '0)
                        - (i_rd_valid ? OUT_W'(1) : '0);

    dvi_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIXEL_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (i_frame_start),
        .i_push  (w_push),
        .i_wdata (i_rd_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_rd_req      <= 1'b0;
            r_rd_addr     <= FB_BASE;
            r_words_req   <= '0;
            r_outstanding <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_frame_start) begin
                        r_state     <= ST_FETCH;
                        r_rd_addr   <= FB_BASE;
                        r_words_req <= '0;
                    end
                end
                ST_FETCH: begin
                    r_outstanding <= w_out_next;
                    if (i_frame_start) begin
                        if (w_ack) begin
                            r_rd_req <= 1'b0;
                        end
                        // Words still in flight belong to the old frame and must be drained first.
                        if ((w_out_next != '0) || (r_rd_req && !i_rd_ack)) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_rd_addr   <= FB_BASE;
                            r_words_req <= '0;
                        end
                    end else if (w_ack) begin
                        r_rd_req    <= 1'b0;
                        r_rd_addr   <= r_rd_addr + ADDR_W'(BURST_LEN);
                        r_words_req <= r_words_req + WR_W'(BURST_LEN);
                    end else if (!r_rd_req && w_more && w_credit_ok) begin
                        r_rd_req <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_outstanding <= w_out_next;
                    if (w_ack) begin
                        r_rd_req <= 1'b0;
                    end
                    if ((r_outstanding == '0) && !r_rd_req) begin
                        r_state     <= ST_FETCH;
                        r_rd_addr   <= FB_BASE;
                        r_words_req <= '0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_rd_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_red       <= '0;
            r_green     <= '0;
            r_blue      <= '0;
            r_de_out    <= 1'b0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_de_out <= i_dataenable;
            if (w_pop) begin
                r_red   <= w_head.red;
                r_green <= w_head.green;
                r_blue  <= w_head.blue;
            end else begin
                r_red   <= '0;
                r_green <= '0;
                r_blue  <= '0;
            end
            if (i_dataenable && w_fifo_empty) begin
                r_underflow <= 1'b1;
            end
            if (w_fetch && i_rd_valid && w_fifo_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_rd_req    = r_rd_req;
    assign o_rd_addr   = r_rd_addr;
    assign o_red       = r_red;
    assign o_green     = r_green;
    assign o_blue      = r_blue;
    assign o_de_out    = r_de_out;
    assign o_underflow = r_underflow;
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_dvi_line_fetch_controller.sv
// Directed bench for dvi_line_fetch_controller with a small memory responder
// (ack 2 cycles after request, burst data 3 cycles after ack).
module tb_dvi_line_fetch_controller;
    import dvi_video_pkg::*;

    localparam int          BURST  = 4;
    localparam logic [23:0] BASE   = 24'h000100;

    logic        clk;
    logic        reset;
    logic        frame_start;
    logic        dataenable;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic        rd_ack;
    logic        rd_valid;
    logic [23:0] rd_data;
    logic [7:0]  red, green, blue;
    logic        de_out, underflow, overflow;

    logic        m_valid;
    logic [23:0] m_data;
    logic        t_valid;
    logic [23:0] t_data;
    logic        mem_en;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          age     = 0;
    int          data_n  = 0;
    int          guard;
    logic        seen_req;
    logic [23:0] q_dat [$];
    int          q_due [$];
    logic [23:0] req_log [$];

    assign rd_valid = m_valid | t_valid;
    assign rd_data  = t_valid ? t_data : m_data;

    dvi_line_fetch_controller #(
        .H_ACTIVE   (8),
        .V_ACTIVE   (2),
        .FIFO_DEPTH (16),
        .BURST_LEN  (BURST),
        .ADDR_W     (24),
        .FB_BASE    (BASE)
    ) u_dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_frame_start (frame_start),
        .i_dataenable  (dataenable),
        .o_rd_req      (rd_req),
        .o_rd_addr     (rd_addr),
        .i_rd_ack      (rd_ack),
        .i_rd_valid    (rd_valid),
        .i_rd_data     (rd_data),
        .o_red         (red),
        .o_green       (green),
        .o_blue        (blue),
        .o_de_out      (de_out),
        .o_underflow   (underflow),
        .o_overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory port model: pixel n of the frame carries 0x010203 + n.
    always @(negedge clk) begin
        cyc = cyc + 1;
        m_valid = 1'b0;
        if (!mem_en) begin
            rd_ack = 1'b0;
            age = 0;
            q_dat.delete();
            q_due.delete();
        end else begin
            if (rd_ack) begin
                rd_ack = 1'b0;
                age = 0;
            end else if (rd_req) begin
                age = age + 1;
                if (age == 2) begin
                    rd_ack = 1'b1;
                    req_log.push_back(rd_addr);
                    for (int i = 0; i < BURST; i++) begin
                        q_dat.push_back(24'h010203 + 24'(data_n));
                        q_due.push_back(cyc + 3);
                        data_n = data_n + 1;
                    end
                end
            end else begin
                age = 0;
            end
            if (q_due.size() > 0 && q_due[0] <= cyc) begin
                m_valid = 1'b1;
                m_data  = q_dat.pop_front();
                void'(q_due.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        mem_en = 1'b0;
        frame_start = 1'b0;
        dataenable = 1'b0;
        t_valid = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        req_log.delete();
        data_n = 0;
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        frame_start = 1'b0;
        dataenable = 1'b0;
        t_valid = 1'b0;
        t_data = '0;
        m_valid = 1'b0;
        m_data = '0;
        rd_ack = 1'b0;
        mem_en = 1'b0;
        do_reset();

        // Reset state and idle behaviour
        check("rst_rgb", {8'h0, red, green, blue}, 32'h0);
        check("rst_de_out", 32'(de_out), 32'h0);
        check("rst_underflow", 32'(underflow), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_rd_req", 32'(rd_req), 32'h0);
        check("rst_rd_addr", 32'(rd_addr), 32'h100);
        check("rst_state", 32'(u_dut.r_state), 32'(ST_IDLE));
        seen_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen_req = seen_req | rd_req;
        end
        check("idle_no_req", 32'(seen_req), 32'h0);

        // Full frame: four bursts fill the 16-entry credit, then 16 pops
        mem_en = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (40) tick();
        check("frame_req_count", 32'(req_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("frame_req_addr%0d", i),
                  (i < req_log.size()) ? 32'(req_log[i]) : 32'hDEADBEEF,
                  32'h100 + 32'(4 * i));
        end
        check("frame_fifo_full_count", 32'(u_dut.w_fifo_count), 32'd16);
        check("frame_de_out_before", 32'(de_out), 32'h0);
        for (int k = 0; k < 16; k++) begin
            dataenable = 1'b1;
            tick();
            check($sformatf("pop%0d_rgb", k), {8'h0, red, green, blue}, 32'h010203 + 32'(k));
            check($sformatf("pop%0d_de_out", k), 32'(de_out), 32'h1);
        end
        dataenable = 1'b0;
        tick();
        check("post_pop_de_out", 32'(de_out), 32'h0);
        check("post_pop_rgb", {8'h0, red, green, blue}, 32'h0);
        repeat (10) tick();
        check("frame_no_fifth_req", 32'(req_log.size()), 32'd4);
        check("frame_rd_req_low", 32'(rd_req), 32'h0);
        check("frame_underflow", 32'(underflow), 32'h0);

        // Underflow: pixel demanded before any data has returned
        do_reset();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        dataenable = 1'b1;
        tick();
        dataenable = 1'b0;
        check("uf_rgb_black", {8'h0, red, green, blue}, 32'h0);
        check("uf_de_out", 32'(de_out), 32'h1);
        check("uf_flag", 32'(underflow), 32'h1);
        repeat (5) tick();
        check("uf_sticky", 32'(underflow), 32'h1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        check("uf_sticky_frame", 32'(underflow), 32'h1);
        do_reset();
        check("uf_cleared_by_reset", 32'(underflow), 32'h0);

        // Drain: frame_start with one burst of 4 words in flight
        mem_en = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        guard = 0;
        while (req_log.size() < 1 && guard < 20) begin
            tick();
            guard++;
        end
        check("drain_first_ack", 32'(req_log.size()), 32'd1);
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("drain_state", 32'(u_dut.r_state), 32'(ST_DRAIN));
        check("drain_outstanding", 32'(u_dut.r_outstanding), 32'd4);
        check("drain_fifo_flushed", 32'(u_dut.w_fifo_count), 32'd0);
        repeat (5) tick();
        check("drain_words_retired", 32'(u_dut.r_outstanding), 32'd0);
        check("drain_fifo_discard", 32'(u_dut.w_fifo_count), 32'd0);
        check("drain_no_req_yet", 32'(rd_req), 32'h0);
        guard = 0;
        while (!rd_req && guard < 20) begin
            tick();
            guard++;
        end
        check("restart_req", 32'(rd_req), 32'h1);
        check("restart_addr", 32'(rd_addr), 32'h100);
        check("restart_state", 32'(u_dut.r_state), 32'(ST_FETCH));
        repeat (2) tick();
        check("restart_ack_count", 32'(req_log.size()), 32'd2);
        check("restart_logged_addr",
              (req_log.size() > 1) ? 32'(req_log[1]) : 32'hDEADBEEF, 32'h100);

        // Overflow: forced words with no credit until the FIFO is full
        do_reset();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            t_valid = 1'b1;
            t_data = 24'hA00000 + 24'(i);
            tick();
        end
        t_valid = 1'b0;
        tick();
        check("of_not_yet", 32'(overflow), 32'h0);
        check("of_fifo_full", 32'(u_dut.w_fifo_count), 32'd16);
        t_valid = 1'b1;
        t_data = 24'hBBBBBB;
        tick();
        t_valid = 1'b0;
        tick();
        check("of_flag", 32'(overflow), 32'h1);
        check("of_count_kept", 32'(u_dut.w_fifo_count), 32'd16);
        for (int k = 0; k < 16; k++) begin
            dataenable = 1'b1;
            tick();
            check($sformatf("of_pop%0d", k), {8'h0, red, green, blue}, 32'hA00000 + 32'(k));
        end
        dataenable = 1'b0;
        tick();
        check("of_sticky", 32'(overflow), 32'h1);
        check("of_fifo_empty", 32'(u_dut.w_fifo_count), 32'd0);
        check("of_no_underflow", 32'(underflow), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dvi_line_fetch_controller.md
Name: dvi_line_fetch_controller

Overview:
- Schedules framebuffer reads for the DVI pixel path.
- Issues burst read requests to a memory port, buffers the returned pixels in a FIFO, and pops one pixel per dataenable cycle.
- Outputs R/G/B bytes and a delayed dataenable, aligned with each other, to feed the three TMDS encoders.
- Sits between the timing controller, the memory controller port and the encoders, all in the pixel clock domain.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame. H_ACTIVE*V_ACTIVE must be a multiple of BURST_LEN.
- FIFO_DEPTH, 32, pixel FIFO entries; power of two, at least 2*BURST_LEN.
- BURST_LEN, 8, words per read request.
- ADDR_W, 24, word address width.
- FB_BASE, 0, word address of pixel (0,0).

Ports:
- clk  in  1  pixel clock (pixel_clk1x).
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse from timing at the start of vertical blank.
- dataenable  in  1  active-video strobe from timing.
- rd_req  out  1  burst read request.
- rd_addr  out  ADDR_W  burst start word address.
- rd_ack  in  1  request accepted this cycle.
- rd_valid  in  1  read data word valid.
- rd_data  in  24  pixel word {R[23:16], G[15:8], B[7:0]}.
- red, green, blue  out  8 each  pixel bytes to the encoders.
- de_out  out  1  dataenable delayed by 1 cycle.
- underflow  out  1  sticky flag: a pixel was needed while the FIFO was empty.
- overflow  out  1  sticky flag: rd_valid arrived while the FIFO was full.

Behaviour:
- Reset: rd_req=0, rd_addr=FB_BASE, red/green/blue=0, de_out=0, underflow=0, overflow=0. FIFO empty, outstanding=0, words_requested=0, state=IDLE.
- States:
  - IDLE: on frame_start -> FETCH; load rd_addr=FB_BASE; clear words_requested.
  - FETCH: rd_req is asserted when all hold: words_requested < H_ACTIVE*V_ACTIVE, rd_req not already high, and fifo_count + outstanding + BURST_LEN <= FIFO_DEPTH.
    - rd_req and rd_addr stay stable until rd_ack. rd_ack while rd_req=1 completes the request that cycle.
    - On completion: outstanding += BURST_LEN, rd_addr += BURST_LEN, words_requested += BURST_LEN, rd_req drops for at least one cycle.
    - Once all words are requested, no further requests are made; stay in FETCH until frame_start.
  - DRAIN: entered on frame_start from FETCH when outstanding != 0 or a request is pending.
    - rd_req is held until its rd_ack, and that burst is counted as outstanding.
    - Incoming rd_valid words are discarded; outstanding decrements per word.
    - Stay until outstanding==0 and rd_req==0, then load FB_BASE, clear words_requested, go to FETCH.
  - frame_start in FETCH with outstanding==0 and no pending request: restart directly in FETCH.
- FIFO flush on every frame_start.
- rd_valid in FETCH: push rd_data and decrement outstanding in the same cycle.
- If the FIFO is full on rd_valid, drop the word and set overflow. Unreachable under the credit rule; it flags a memory-side protocol error.
- Pixel pop: when dataenable=1, pop the FIFO head and register it to red/green/blue next cycle. de_out equals the previous cycle's dataenable, so latency is 1 cycle.
- Empty FIFO on dataenable: output 0/0/0 (black), no pop, set underflow.
- dataenable=0: red/green/blue=0.
- Simultaneous push and pop: fifo_count unchanged; a pop from a FIFO holding one entry while pushing is legal.
- underflow and overflow are cleared only by reset.
- Counter and address arithmetic: unsigned, wrap modulo 2^width. words_requested is $clog2(H_ACTIVE*V_ACTIVE+1) bits wide.
- Asynchronous reset mid-burst: immediately returns to reset values. Words arriving after reset are ignored because state=IDLE.

Decomposition:
- Shared package dvi_video_pkg:
  - pixel word typedef (24-bit RGB) with byte field positions;
  - state encoding localparams (IDLE, FETCH, DRAIN).
- One sub-module: dvi_pixel_fifo, a synchronous FIFO parameterised by depth and width.
  - Provides count, full and empty outputs.
  - Supports push and pop in the same cycle.
  - Uses asynchronous active-high reset.

Test Plan (params H_ACTIVE=8, V_ACTIVE=2, FIFO_DEPTH=16, BURST_LEN=4, FB_BASE=0x100):
- Reset, then idle cycles: all outputs are 0 and rd_addr=0x100; no rd_req before frame_start.
- frame_start, rd_ack after 2 cycles each request, data 0x010203+n 3 cycles later:
  - requests at 0x100, 0x104, 0x108, 0x10C and no more (credit limit of 16);
  - dataenable pops produce R=0x01, G=0x02, B=0x03+n with de_out lagging 1 cycle.
- Full frame of 16 pops: exactly 4 requests, the last at 0x10C; no fifth request; underflow=0.
- dataenable asserted before the first data returns: output 0/0/0, underflow=1 and stays 1 until reset.
- frame_start while 4 words are outstanding:
  - state goes to DRAIN and all 4 words are discarded;
  - the next request goes to 0x100 after the last discarded word;
  - FIFO count is 0 after frame_start.
- rd_valid injected with the FIFO full (forced): overflow=1; the FIFO contents are unchanged.
